// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state encoding and default sizing for the SPI master sequencer
package spi_seq_pkg;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 2;
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: end-of-half-period tick generator
// Ports: CLK clock, CLR async active-low reset, EN count enable (clears the count when low),
//        TICK high on the last cycle of each CLK_DIV-cycle half period.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic EN,
  output logic TICK
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] cnt;
  assign TICK = EN && (cnt == CW'(CLK_DIV - 1));
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) cnt <= '0;
    else cnt <= (!EN || TICK) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master_sequencer.sv
// spi_master_sequencer: single-buffered SPI master (CPOL=0/CPHA=0) with optional CS hold between frames
// Ports: CLK clock, CLR async active-low reset
//        host side: WRITE/TX_DATA load the holding register, READ acknowledges RX_DATA,
//                   HOLD_CS keeps CS low across back-to-back frames,
//                   RX_DATA/RX_VALID/OVERRUN receive status, TX_FULL holding register occupied, BUSY frame active
//        SPI side:  S_CLK, MOSI (MSB first), MISO, CS (active low)
module spi_master_sequencer
  import spi_seq_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WRITE,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              READ,
  input  logic              HOLD_CS,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              TX_FULL,
  output logic              BUSY,
  output logic              OVERRUN,
  input  logic              MISO,
  output logic              MOSI,
  output logic              S_CLK,
  output logic              CS
);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  state_t state, state_nx;
  logic tick, last, load, sample, shift_en, done;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] hold, tx_shift, rx_shift;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .CLK (CLK),
    .CLR (CLR),
    .EN  (state != IDLE),
    .TICK(tick)
  );

  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    sample   = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    last     = bit_cnt == BW'(DATA_W - 1);
    case (state)
      IDLE: if (TX_FULL) begin
        state_nx = LEAD;
        load     = 1'b1;
      end
      LEAD, LOW: if (tick) begin
        state_nx = HIGH;
        sample   = 1'b1;
      end
      HIGH: if (tick) begin
        if (!last) begin
          state_nx = LOW;
          shift_en = 1'b1;
        end else begin
          done = 1'b1;
          // back-to-back frame: reload and go straight to LOW so CS never rises
          if (HOLD_CS && TX_FULL) begin
            state_nx = LOW;
            load     = 1'b1;
          end else state_nx = TRAIL;
        end
      end
      TRAIL: if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    CS    = state == IDLE;
    BUSY  = state != IDLE;
    S_CLK = state == HIGH;
    MOSI  = (state != IDLE) && tx_shift[DATA_W-1];
  end

  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      hold     <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      TX_FULL  <= 1'b0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      if (load) tx_shift <= hold;
      else if (shift_en) tx_shift <= tx_shift << 1;
      if (sample) rx_shift <= DATA_W'({rx_shift, MISO});
      bit_cnt <= done ? '0 : shift_en ? bit_cnt + 1'b1 : bit_cnt;
      // a write that coincides with a load refills the register being emptied
      if (WRITE && (!TX_FULL || load)) begin
        hold    <= TX_DATA;
        TX_FULL <= 1'b1;
      end else if (load) TX_FULL <= 1'b0;
      // completion outranks a coincident READ
      if (done) begin
        RX_DATA  <= rx_shift;
        RX_VALID <= 1'b1;
        OVERRUN  <= OVERRUN | (RX_VALID & ~READ);
      end else if (READ) begin
        RX_VALID <= 1'b0;
        OVERRUN  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_master_sequencer.sv
// tb_spi_master_sequencer: randomized self-checking bench with a transaction-level SPI reference model
module tb_spi_master_sequencer;
  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 8;
  localparam int LIMIT   = 2000;

  logic CLK = 0, CLR = 0, WRITE = 0, READ = 0, HOLD_CS = 0, MISO = 0;
  logic [7:0] TX_DATA = 0;
  logic [7:0] RX_DATA;
  logic RX_VALID, TX_FULL, BUSY, OVERRUN, MOSI, S_CLK, CS;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  spi_master_sequencer #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .CLR(CLR), .WRITE(WRITE), .TX_DATA(TX_DATA), .READ(READ), .HOLD_CS(HOLD_CS),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .TX_FULL(TX_FULL), .BUSY(BUSY), .OVERRUN(OVERRUN),
    .MISO(MISO), .MOSI(MOSI), .S_CLK(S_CLK), .CS(CS)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  int q[$];
  int rx_hist[$];
  logic loop = 0;
  int bits = 0, frames = 0, cs_low = 0, sclk_hi = 0, last_burst = 0;
  logic [7:0] txb = 0, rxb = 0, mdata = 0;
  logic mvalid = 0, movr = 0, prev_sclk = 0, prev_cs = 1, prev_read = 0, prev_miso = 0, comp;

  // bus-level reference: frames are reconstructed from S_CLK/MOSI, RX from the MISO bits driven
  always @(negedge CLK) begin
    comp = 0;
    if (!CLR) begin
      q.delete();
      bits = 0; frames = 0; cs_low = 0; sclk_hi = 0;
      mvalid = 0; movr = 0; mdata = 0;
    end else begin
      if (S_CLK && !prev_sclk) begin
        txb = {txb[6:0], MOSI};
        rxb = {rxb[6:0], prev_miso};
        bits++;
      end
      if (S_CLK) sclk_hi++;
      if (!S_CLK && prev_sclk) begin
        chk("sclk_high_len", 32'(sclk_hi), CLK_DIV);
        sclk_hi = 0;
        if (bits == 8) begin
          comp = 1;
          chk("mosi_byte", 32'(txb), q.size() ? q.pop_front() : 32'h100);
          if (mvalid && !prev_read) movr = 1;
          mvalid = 1;
          mdata = rxb;
          rx_hist.push_back(int'(rxb));
          bits = 0;
          frames++;
        end
      end
      if (!comp && prev_read) begin
        mvalid = 0;
        movr = 0;
      end
      if (!CS) cs_low++;
      if (CS && !prev_cs) begin
        chk("cs_low_len", 32'(cs_low), CLK_DIV * (1 + 16 * frames));
        chk("bits_at_cs_rise", 32'(bits), 0);
        last_burst = frames;
        frames = 0;
        cs_low = 0;
      end
      if (CS) chk("mosi_idle", 32'(MOSI), 0);
      chk("rx_valid", 32'(RX_VALID), 32'(mvalid));
      chk("overrun", 32'(OVERRUN), 32'(movr));
      chk("rx_data", 32'(RX_DATA), 32'(mdata));
    end
    prev_sclk = S_CLK;
    prev_cs = CS;
    prev_read = READ;
    MISO = loop ? MOSI : 1'($urandom_range(0, 1));
    prev_miso = MISO;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic keep);
    TX_DATA = d;
    WRITE = 1;
    if (keep) q.push_back(int'(d));
    step(1);
    WRITE = 0;
  endtask

  task automatic rd();
    READ = 1;
    step(1);
    READ = 0;
  endtask

  task automatic wait_free();
    for (int i = 0; i < LIMIT; i++) begin
      if (!TX_FULL) return;
      step(1);
    end
    chk("wait_free_timeout", 32'(TX_FULL), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < LIMIT; i++) begin
      if (!BUSY && !TX_FULL) return;
      step(1);
    end
    chk("wait_idle_timeout", 32'(BUSY), 0);
  endtask

  initial begin
    step(3);
    chk("rst_cs", 32'(CS), 1);
    chk("rst_sclk", 32'(S_CLK), 0);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_tx_full", 32'(TX_FULL), 0);
    chk("rst_rx_valid", 32'(RX_VALID), 0);
    chk("rst_overrun", 32'(OVERRUN), 0);
    chk("rst_rx_data", 32'(RX_DATA), 0);
    CLR = 1;
    step(2);

    loop = 1;
    wr(8'hA5, 1);
    chk("a5_tx_full", 32'(TX_FULL), 1);
    wait_idle();
    chk("a5_rx_data", 32'(RX_DATA), 32'hA5);
    chk("a5_rx_valid", 32'(RX_VALID), 1);
    rd();
    step(1);

    HOLD_CS = 1;
    wr(8'h3C, 1);
    wait_free();
    wr(8'hC3, 1);
    wait_idle();
    step(2);
    chk("hold_burst_frames", 32'(last_burst), 2);
    chk("hold_rx_first", 32'(rx_hist[rx_hist.size() - 2]), 32'h3C);
    chk("hold_rx_second", 32'(rx_hist[rx_hist.size() - 1]), 32'hC3);
    chk("ovr_set", 32'(OVERRUN), 1);
    chk("ovr_rx_data", 32'(RX_DATA), 32'hC3);
    rd();
    chk("read_clears_valid", 32'(RX_VALID), 0);
    chk("read_clears_ovr", 32'(OVERRUN), 0);

    HOLD_CS = 0;
    wr(8'h11, 1);
    wait_free();
    wr(8'h22, 1);
    wait_free();
    chk("second_load_clears", 32'(TX_FULL), 0);
    wait_idle();
    step(2);
    chk("nohold_burst_frames", 32'(last_burst), 1);

    wr(8'h55, 1);
    wait_free();
    wr(8'h66, 1);
    chk("drop_precond", 32'(TX_FULL & BUSY), 1);
    wr(8'h77, 0);
    wait_idle();
    rd();

    wr(8'h9A, 1);
    begin
      int rises = 0;
      logic ps = 0;
      for (int i = 0; i < LIMIT && rises < 5; i++) begin
        step(1);
        if (S_CLK && !ps) rises++;
        ps = S_CLK;
      end
      chk("reset_rises", 32'(rises), 5);
    end
    CLR = 0;
    #1;
    chk("mid_rst_cs", 32'(CS), 1);
    chk("mid_rst_sclk", 32'(S_CLK), 0);
    chk("mid_rst_rx_valid", 32'(RX_VALID), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    @(posedge CLK);
    #1;
    step(2);
    CLR = 1;
    step(3);
    chk("post_rst_idle", 32'(BUSY), 0);
    wr(8'h81, 1);
    wait_idle();
    chk("post_rst_rx", 32'(RX_DATA), 32'h81);
    loop = 0;

    for (int it = 0; it < 80; it++) begin
      HOLD_CS = 1'($urandom_range(0, 1));
      step($urandom_range(0, 40));
      case ($urandom_range(0, 3))
        0: rd();
        3: if (TX_FULL && BUSY) begin
          HOLD_CS = 0;
          wr(8'($urandom), 0);
        end
        default: if (!TX_FULL) wr(8'($urandom), 1);
      endcase
    end
    wait_idle();
    step(4);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
